// File: rtl/ddr_init_seq.sv
// DDR bring-up/reset sequencer: holds the system in reset until the DDR3 controller is
// locked, initialised and stable; retries calibration via controller soft reset, then fails sticky.
module ddr_init_seq #(
   parameter int STABLE_CYCLES   = 256,
   parameter int INIT_TIMEOUT    = 1048576,
   parameter int SOFT_RST_CYCLES = 64,
   parameter int MAX_RETRY       = 3,
   parameter int CNT_W           = 21
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       init_done,
   input  logic       cal_fail,
   output logic       sys_rst_o,
   output logic       ddr_soft_rst_o,
   output logic       ddr_ready_o,
   output logic       init_fail_o,
   output logic [1:0] retry_cnt_o,
   output logic [2:0] state_o
);

   localparam logic [2:0] S_WAIT_LOCK = 3'd0;
   localparam logic [2:0] S_WAIT_INIT = 3'd1;
   localparam logic [2:0] S_STABLE    = 3'd2;
   localparam logic [2:0] S_RUN       = 3'd3;
   localparam logic [2:0] S_RECOVER   = 3'd4;
   localparam logic [2:0] S_FAIL      = 3'd5;

   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] INIT_LAST   = CNT_W'(INIT_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] SOFT_LAST   = CNT_W'(SOFT_RST_CYCLES - 1);

   // Internal retry counter is wide enough for MAX_RETRY; the debug port saturates at 3.
   localparam int RETRY_W = (MAX_RETRY > 3) ? $clog2(MAX_RETRY + 1) : 2;
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

   function automatic logic [1:0] sat_retry(input logic [RETRY_W-1:0] v);
      logic [1:0] r;
      if (v > RETRY_W'(3)) begin
         r = 2'd3;
      end else begin
         r = v[1:0];
      end
      return r;
   endfunction

   // bit 0 = pll_locked, bit 1 = init_done, bit 2 = cal_fail
   logic [2:0] meta_q, meta_d;
   logic [2:0] sync_q, sync_d;
   logic       locked_s, init_done_s, cal_fail_s;

   logic [2:0]         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [RETRY_W-1:0] retry_q, retry_d;

   logic       sys_rst_q, sys_rst_d;
   logic       soft_rst_q, soft_rst_d;
   logic       ready_q, ready_d;
   logic       fail_q, fail_d;
   logic [1:0] retry_cnt_q, retry_cnt_d;

   assign locked_s    = sync_q[0];
   assign init_done_s = sync_q[1];
   assign cal_fail_s  = sync_q[2];

   // Two-stage synchronizer chain for each asynchronous status input.
   always_comb begin
      meta_d = {cal_fail, init_done, pll_locked};
      sync_d = meta_q;
   end

   // Next-state, retry bookkeeping and shared counter.
   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      cnt_d   = '0;
      case (state_q)
         S_WAIT_LOCK: begin
            if (locked_s) begin
               state_d = S_WAIT_INIT;
            end else begin
               state_d = S_WAIT_LOCK;
            end
         end
         S_WAIT_INIT: begin
            if (!locked_s) begin
               state_d = S_WAIT_LOCK;
            end else if (cal_fail_s || (cnt_q == INIT_LAST)) begin
               // A calibration failure wins over a simultaneous init-done.
               if (retry_q == RETRY_MAX) begin
                  state_d = S_FAIL;
               end else begin
                  state_d = S_RECOVER;
                  retry_d = retry_q + RETRY_W'(1);
               end
            end else if (init_done_s) begin
               state_d = S_STABLE;
            end else begin
               state_d = S_WAIT_INIT;
            end
         end
         S_STABLE: begin
            if (!locked_s || !init_done_s) begin
               state_d = S_WAIT_LOCK;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = S_RUN;
               retry_d = '0;
            end else begin
               state_d = S_STABLE;
            end
         end
         S_RUN: begin
            if (!locked_s || !init_done_s) begin
               state_d = S_WAIT_LOCK;
            end else begin
               state_d = S_RUN;
            end
         end
         S_RECOVER: begin
            if (cnt_q == SOFT_LAST) begin
               state_d = S_WAIT_LOCK;
            end else begin
               state_d = S_RECOVER;
            end
         end
         S_FAIL: begin
            state_d = S_FAIL;
         end
         default: begin
            state_d = S_WAIT_LOCK;
            retry_d = '0;
         end
      endcase

      // The counter only advances in the timed states and restarts on any state change.
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if ((state_q == S_WAIT_INIT) || (state_q == S_STABLE) ||
                   (state_q == S_RECOVER)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = '0;
      end
   end

   // Output decode from the next state so outputs change on the same edge as the state.
   always_comb begin
      sys_rst_d   = (state_d != S_RUN);
      ready_d     = (state_d == S_RUN);
      soft_rst_d  = (state_d == S_RECOVER);
      fail_d      = (state_d == S_FAIL);
      retry_cnt_d = sat_retry(retry_d);
   end

   // State, counter, synchronizer and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q      <= 3'b000;
         sync_q      <= 3'b000;
         state_q     <= S_WAIT_LOCK;
         cnt_q       <= '0;
         retry_q     <= '0;
         sys_rst_q   <= 1'b1;
         soft_rst_q  <= 1'b0;
         ready_q     <= 1'b0;
         fail_q      <= 1'b0;
         retry_cnt_q <= 2'd0;
      end else begin
         meta_q      <= meta_d;
         sync_q      <= sync_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         sys_rst_q   <= sys_rst_d;
         soft_rst_q  <= soft_rst_d;
         ready_q     <= ready_d;
         fail_q      <= fail_d;
         retry_cnt_q <= retry_cnt_d;
      end
   end

   assign sys_rst_o      = sys_rst_q;
   assign ddr_soft_rst_o = soft_rst_q;
   assign ddr_ready_o    = ready_q;
   assign init_fail_o    = fail_q;
   assign retry_cnt_o    = retry_cnt_q;
   assign state_o        = state_q;

endmodule

// File: tb/tb_ddr_init_seq.sv
// Directed bench for ddr_init_seq: expected output vectors are queued per edge number
// and popped/compared on the falling clock edge once that edge has occurred.
module tb_ddr_init_seq;

   logic       clk;
   logic       rst;
   logic       pll_locked;
   logic       init_done;
   logic       cal_fail;
   logic       sys_rst_o;
   logic       ddr_soft_rst_o;
   logic       ddr_ready_o;
   logic       init_fail_o;
   logic [1:0] retry_cnt_o;
   logic [2:0] state_o;

   int edge_n = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      string      tag;
      int         edge_no;
      logic [8:0] vec;
   } exp_t;

   exp_t sb[$];

   ddr_init_seq #(
      .STABLE_CYCLES   (4),
      .INIT_TIMEOUT    (16),
      .SOFT_RST_CYCLES (8),
      .MAX_RETRY       (2),
      .CNT_W           (5)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .pll_locked     (pll_locked),
      .init_done      (init_done),
      .cal_fail       (cal_fail),
      .sys_rst_o      (sys_rst_o),
      .ddr_soft_rst_o (ddr_soft_rst_o),
      .ddr_ready_o    (ddr_ready_o),
      .init_fail_o    (init_fail_o),
      .retry_cnt_o    (retry_cnt_o),
      .state_o        (state_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Edge 1 is the first rising edge with rst low.
   always @(posedge clk) begin
      edge_n <= rst ? 0 : edge_n + 1;
   end

   // Vector layout: {sys_rst, ready, soft_rst, init_fail, retry_cnt[1:0], state[2:0]}
   task automatic push(input string tag, input int e, input logic s, input logic r,
                       input logic sr, input logic f, input logic [1:0] rc,
                       input logic [2:0] st);
      exp_t x;
      x.tag     = tag;
      x.edge_no = e;
      x.vec     = {s, r, sr, f, rc, st};
      sb.push_back(x);
   endtask

   task automatic tick();
      exp_t       x;
      logic [8:0] obs;
      @(negedge clk);
      while (sb.size() > 0 && sb[0].edge_no <= edge_n) begin
         x   = sb.pop_front();
         obs = {sys_rst_o, ddr_ready_o, ddr_soft_rst_o, init_fail_o, retry_cnt_o, state_o};
         checks++;
         assert (x.edge_no == edge_n && obs === x.vec) else begin
            errors++;
            $error("FAIL %s edge %0d (now %0d): observed %b expected %b",
                   x.tag, x.edge_no, edge_n, obs, x.vec);
         end
      end
   endtask

   task automatic run_to(input int e);
      int guard;
      guard = 0;
      while (edge_n < e && guard < 500) begin
         tick();
         guard++;
      end
      if (guard >= 500) begin
         errors++;
         $error("FAIL run_to: edge %0d never reached (now %0d)", e, edge_n);
      end
   endtask

   task automatic do_reset(input logic l, input logic i, input logic c);
      rst        = 1'b1;
      pll_locked = l;
      init_done  = i;
      cal_fail   = c;
      tick();
      tick();
      push("reset_vals", 0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0);
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      pll_locked = 1'b0;
      init_done  = 1'b0;
      cal_fail   = 1'b0;

      // Clean bring-up, then lock loss in RUN and re-release.
      do_reset(1'b1, 1'b1, 1'b0);
      push("clean_e2",    2,  1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0);
      push("clean_e3",    3,  1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd1);
      push("clean_e4",    4,  1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd2);
      push("clean_e7",    7,  1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd2);
      push("clean_run",   8,  1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd3);
      push("loss_e12",    12, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd3);
      push("loss_e13",    13, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0);
      push("relock_e15",  15, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0);
      push("relock_e16",  16, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd1);
      push("relock_e20",  20, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd2);
      push("relock_run",  21, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd3);
      run_to(10);
      pll_locked = 1'b0;
      run_to(13);
      pll_locked = 1'b1;
      run_to(22);

      // One-cycle init_done glitch while in STABLE.
      do_reset(1'b1, 1'b1, 1'b0);
      push("glitch_e4",   4,  1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd2);
      push("glitch_e6",   6,  1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd2);
      push("glitch_e7",   7,  1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0);
      push("glitch_e8",   8,  1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd1);
      push("glitch_e9",   9,  1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd2);
      push("glitch_e12",  12, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd2);
      push("glitch_run",  13, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd3);
      run_to(4);
      init_done = 1'b0;
      run_to(5);
      init_done = 1'b1;
      run_to(14);

      // Init timeout -> one retry, then a successful bring-up clears the retry count.
      do_reset(1'b1, 1'b0, 1'b0);
      push("tmo_e3",      3,  1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd1);
      push("tmo_e18",     18, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd1);
      push("tmo_recover", 19, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 3'd4);
      push("tmo_e26",     26, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 3'd4);
      push("tmo_e27",     27, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0);
      push("tmo_e28",     28, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 3'd1);
      push("tmo_e29",     29, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 3'd2);
      push("tmo_e32",     32, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 3'd2);
      push("tmo_run",     33, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd3);
      run_to(19);
      init_done = 1'b1;
      run_to(34);

      // cal_fail held high: two recover pulses then sticky FAIL.
      do_reset(1'b1, 1'b0, 1'b1);
      push("exh_e3",      3,  1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd1);
      push("exh_rec1",    4,  1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 3'd4);
      push("exh_e11",     11, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 3'd4);
      push("exh_e12",     12, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0);
      push("exh_e13",     13, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 3'd1);
      push("exh_rec2",    14, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 3'd4);
      push("exh_e21",     21, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 3'd4);
      push("exh_e22",     22, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 3'd0);
      push("exh_e23",     23, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 3'd1);
      push("exh_fail",    24, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 3'd5);
      push("exh_sticky",  40, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 3'd5);
      run_to(26);
      pll_locked = 1'b0;
      cal_fail   = 1'b0;
      run_to(40);

      // cal_fail and init_done rising together must recover; rst then truncates the pulse.
      do_reset(1'b1, 1'b0, 1'b0);
      push("simul_e3",    3,  1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd1);
      push("simul_e7",    7,  1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd1);
      push("simul_e8",    8,  1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 3'd4);
      push("simul_e10",   10, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 3'd4);
      run_to(5);
      init_done = 1'b1;
      cal_fail  = 1'b1;
      run_to(10);

      do_reset(1'b1, 1'b1, 1'b0);
      push("after_rst_e7",  7, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd2);
      push("after_rst_run", 8, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd3);
      run_to(9);

      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL scoreboard_drain: observed %0d entries left, expected 0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
